// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward selects,
// and the shadow scoreboard entry that tracks one in-flight destination.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_STALL = 2'd1,
    CTRL_FLUSH = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
  } sb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a used source operand reads the destination held in this entry.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] rs, input logic used);
    return used && e.valid && e.reg_write && (e.rd != REG_ZERO) && (rs == e.rd);
  endfunction

endpackage

// File: rtl/saturating_counter.sv
// Event counter that counts up by one per enabled cycle and holds at all-ones.
module saturating_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (increment && (count_q != {WIDTH{1'b1}})) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forwarding controller for a fetch/decode/execute pipeline, driven only by
// decode-stage inputs plus a shadow scoreboard of the EX and MEM destinations.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int FORWARD_EN    = 1,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     decodeValid,
  input  logic [4:0]               decodeRs1,
  input  logic [4:0]               decodeRs2,
  input  logic                     decodeRs1Used,
  input  logic                     decodeRs2Used,
  input  logic [4:0]               decodeRd,
  input  logic                     decodeRegisterWriteEnable,
  input  logic                     decodeMemoryReadEnable,
  input  logic                     executeRedirect,
  output logic                     pcWriteEnable,
  output logic                     fetchToDecodeWriteEnable,
  output logic                     fetchToDecodeFlush,
  output logic                     decodeToExecuteFlush,
  output logic [1:0]               forwardSelect1,
  output logic [1:0]               forwardSelect2,
  output logic [1:0]               controllerState,
  output logic [COUNTER_WIDTH-1:0] stallCycleCount,
  output logic [COUNTER_WIDTH-1:0] flushCount
);

  ctrl_state_e state_q, state_d;
  sb_entry_t   ex_q, ex_d;
  sb_entry_t   mem_q, mem_d;
  fwd_sel_e    fwd1_q, fwd1_d;
  fwd_sel_e    fwd2_q, fwd2_d;

  logic decode_active;
  logic ex_hit, mem_hit;
  logic hazard, stall, issue;

  // WB needs no entry: the register file writes through, so WB producers never hazard.
  always_comb begin
    decode_active = decodeValid && (state_q != CTRL_FLUSH);
    ex_hit  = sb_match(ex_q, decodeRs1, decodeRs1Used) || sb_match(ex_q, decodeRs2, decodeRs2Used);
    mem_hit = sb_match(mem_q, decodeRs1, decodeRs1Used) || sb_match(mem_q, decodeRs2, decodeRs2Used);
    if (FORWARD_EN != 0) hazard = decode_active && ex_hit && ex_q.is_load;
    else                 hazard = decode_active && (ex_hit || mem_hit);
    stall = hazard && !executeRedirect;
    issue = decode_active && !stall && !executeRedirect;
  end

  always_comb begin
    ex_d   = '0;
    mem_d  = ex_q;
    fwd1_d = FWD_REG;
    fwd2_d = FWD_REG;
    if (issue) begin
      ex_d = '{valid: 1'b1, rd: decodeRd, reg_write: decodeRegisterWriteEnable,
               is_load: decodeMemoryReadEnable};
      if (FORWARD_EN != 0) begin
        if (sb_match(ex_q, decodeRs1, decodeRs1Used))       fwd1_d = FWD_MEM;
        else if (sb_match(mem_q, decodeRs1, decodeRs1Used)) fwd1_d = FWD_WB;
        if (sb_match(ex_q, decodeRs2, decodeRs2Used))       fwd2_d = FWD_MEM;
        else if (sb_match(mem_q, decodeRs2, decodeRs2Used)) fwd2_d = FWD_WB;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_q   <= '0;
      mem_q  <= '0;
      fwd1_q <= FWD_REG;
      fwd2_q <= FWD_REG;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= CTRL_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = CTRL_RUN;
    if (executeRedirect) state_d = CTRL_FLUSH;
    else if (stall)      state_d = CTRL_STALL;
  end

  always_comb begin
    pcWriteEnable            = !stall;
    fetchToDecodeWriteEnable = !stall;
    fetchToDecodeFlush       = executeRedirect;
    decodeToExecuteFlush     = executeRedirect || stall;
    forwardSelect1           = fwd1_q;
    forwardSelect2           = fwd2_q;
    controllerState          = state_q;
  end

  saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_counter (
    .clock     (clock),
    .reset     (reset),
    .increment (stall),
    .count     (stallCycleCount)
  );

  saturating_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_counter (
    .clock     (clock),
    .reset     (reset),
    .increment (executeRedirect),
    .count     (flushCount)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: one forwarding controller (16-bit counters) and one non-forwarding
// controller (2-bit counters) sharing decode inputs, each with its own reset.
module tb_pipeline_hazard_controller;

  localparam logic [1:0] RUN = 2'd0, STL = 2'd1, FLS = 2'd2;
  localparam logic [1:0] F_R = 2'b00, F_M = 2'b01, F_W = 2'b10;

  logic       clock = 1'b0;
  logic       reset_a, reset_b;
  logic       dv, u1, u2, rw, ld, redir;
  logic [4:0] rs1, rs2, rd;

  logic        a_pcwe, a_f2dwe, a_f2dfl, a_d2efl;
  logic [1:0]  a_fs1, a_fs2, a_state;
  logic [15:0] a_stall, a_flush;
  logic        b_pcwe, b_f2dwe, b_f2dfl, b_d2efl;
  logic [1:0]  b_fs1, b_fs2, b_state;
  logic [1:0]  b_stall, b_flush;

  logic [9:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pipeline_hazard_controller #(.FORWARD_EN(1), .COUNTER_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset_a), .decodeValid(dv),
    .decodeRs1(rs1), .decodeRs2(rs2), .decodeRs1Used(u1), .decodeRs2Used(u2),
    .decodeRd(rd), .decodeRegisterWriteEnable(rw), .decodeMemoryReadEnable(ld),
    .executeRedirect(redir), .pcWriteEnable(a_pcwe), .fetchToDecodeWriteEnable(a_f2dwe),
    .fetchToDecodeFlush(a_f2dfl), .decodeToExecuteFlush(a_d2efl),
    .forwardSelect1(a_fs1), .forwardSelect2(a_fs2), .controllerState(a_state),
    .stallCycleCount(a_stall), .flushCount(a_flush)
  );

  pipeline_hazard_controller #(.FORWARD_EN(0), .COUNTER_WIDTH(2)) dut_b (
    .clock(clock), .reset(reset_b), .decodeValid(dv),
    .decodeRs1(rs1), .decodeRs2(rs2), .decodeRs1Used(u1), .decodeRs2Used(u2),
    .decodeRd(rd), .decodeRegisterWriteEnable(rw), .decodeMemoryReadEnable(ld),
    .executeRedirect(redir), .pcWriteEnable(b_pcwe), .fetchToDecodeWriteEnable(b_f2dwe),
    .fetchToDecodeFlush(b_f2dfl), .decodeToExecuteFlush(b_d2efl),
    .forwardSelect1(b_fs1), .forwardSelect2(b_fs2), .controllerState(b_state),
    .stallCycleCount(b_stall), .flushCount(b_flush)
  );

  function automatic logic [9:0] ev(input logic pc, input logic fw, input logic ff, input logic df,
                                    input logic [1:0] f1, input logic [1:0] f2, input logic [1:0] st);
    return {pc, fw, ff, df, f1, f2, st};
  endfunction

  task automatic drive(input logic v, input logic [4:0] r1, input logic s1, input logic [4:0] r2,
                       input logic s2, input logic [4:0] d, input logic w, input logic l,
                       input logic x);
    dv = v; rs1 = r1; u1 = s1; rs2 = r2; u2 = s2; rd = d; rw = w; ld = l; redir = x;
  endtask

  task automatic check_vec(input string tag, input bit on_b);
    logic [9:0] e, o;
    e = exp_q.pop_front();
    o = on_b ? {b_pcwe, b_f2dwe, b_f2dfl, b_d2efl, b_fs1, b_fs2, b_state}
             : {a_pcwe, a_f2dwe, a_f2dfl, a_d2efl, a_fs1, a_fs2, a_state};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed={pcwe,f2dwe,f2dfl,d2efl,fs1,fs2,st}=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Inputs are applied just after a rising edge and outputs sampled on the falling edge.
  task automatic step(input string tag, input bit on_b, input logic [9:0] e);
    exp_q.push_back(e);
    @(negedge clock);
    check_vec(tag, on_b);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    step("reset_a", 0, ev(1, 1, 0, 0, F_R, F_R, RUN));
    check_cnt("reset_stall_a", a_stall, 16'd0);
    check_cnt("reset_flush_a", a_flush, 16'd0);
    reset_a = 1'b0;

    // lw x1,0(x2); add x3,x1,x4
    drive(1, 2, 1, 0, 0, 1, 1, 1, 0); step("lw_x1", 0, ev(1, 1, 0, 0, F_R, F_R, RUN));
    drive(1, 1, 1, 4, 1, 3, 1, 0, 0); step("loaduse_stall", 0, ev(0, 0, 0, 1, F_R, F_R, RUN));
    drive(1, 1, 1, 4, 1, 3, 1, 0, 0); step("loaduse_issue", 0, ev(1, 1, 0, 0, F_R, F_R, STL));
    check_cnt("stall_cnt_loaduse", a_stall, 16'd1);
    // add x1,x2,x3 (x3 from add in EX); sub x5,x1,x1
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0); step("add_x1", 0, ev(1, 1, 0, 0, F_W, F_R, RUN));
    drive(1, 1, 1, 1, 1, 5, 1, 0, 0); step("sub_x5", 0, ev(1, 1, 0, 0, F_R, F_M, RUN));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("fwd_mem_both", 0, ev(1, 1, 0, 0, F_M, F_M, RUN));
    // load-use hazard coinciding with a redirect
    drive(1, 2, 1, 0, 0, 1, 1, 1, 0); step("lw_x1_redir", 0, ev(1, 1, 0, 0, F_R, F_R, RUN));
    drive(1, 1, 1, 4, 1, 3, 1, 0, 1); step("redirect_wins", 0, ev(1, 1, 1, 1, F_R, F_R, RUN));
    check_cnt("flush_cnt_redir", a_flush, 16'd1);
    check_cnt("stall_cnt_redir", a_stall, 16'd1);
    drive(1, 1, 1, 4, 1, 3, 1, 0, 0); step("flush_slot", 0, ev(1, 1, 0, 0, F_R, F_R, FLS));
    drive(1, 3, 1, 0, 0, 7, 1, 0, 0); step("after_flush", 0, ev(1, 1, 0, 0, F_R, F_R, RUN));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("flush_slot_ignored", 0, ev(1, 1, 0, 0, F_R, F_R, RUN));
    // lw x0,0(x2); add x3,x0,x0
    drive(1, 2, 1, 0, 0, 0, 1, 1, 0); step("lw_x0", 0, ev(1, 1, 0, 0, F_R, F_R, RUN));
    drive(1, 0, 1, 0, 1, 3, 1, 0, 0); step("use_x0_no_stall", 0, ev(1, 1, 0, 0, F_R, F_R, RUN));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("x0_no_fwd", 0, ev(1, 1, 0, 0, F_R, F_R, RUN));
    check_cnt("stall_cnt_end_a", a_stall, 16'd1);
    check_cnt("flush_cnt_end_a", a_flush, 16'd1);

    reset_a = 1'b1;
    reset_b = 1'b0;
    step("reset_b", 1, ev(1, 1, 0, 0, F_R, F_R, RUN));
    check_cnt("reset_stall_b", {14'd0, b_stall}, 16'd0);
    // no forwarding: add x1; add x6,x1,x0 stalls twice
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0); step("nf_add_x1", 1, ev(1, 1, 0, 0, F_R, F_R, RUN));
    drive(1, 1, 1, 0, 1, 6, 1, 0, 0); step("nf_stall_ex", 1, ev(0, 0, 0, 1, F_R, F_R, RUN));
    drive(1, 1, 1, 0, 1, 6, 1, 0, 0); step("nf_stall_mem", 1, ev(0, 0, 0, 1, F_R, F_R, STL));
    drive(1, 1, 1, 0, 1, 6, 1, 0, 0); step("nf_issue", 1, ev(1, 1, 0, 0, F_R, F_R, STL));
    check_cnt("nf_stall_cnt_2", {14'd0, b_stall}, 16'd2);
    // MEM producer: one stall cycle
    drive(1, 2, 1, 3, 1, 9, 1, 0, 0); step("nf_add_x9", 1, ev(1, 1, 0, 0, F_R, F_R, RUN));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("nf_gap", 1, ev(1, 1, 0, 0, F_R, F_R, RUN));
    drive(1, 9, 1, 0, 1, 10, 1, 0, 0); step("nf_mem_stall", 1, ev(0, 0, 0, 1, F_R, F_R, RUN));
    drive(1, 9, 1, 0, 1, 10, 1, 0, 0); step("nf_mem_issue", 1, ev(1, 1, 0, 0, F_R, F_R, STL));
    check_cnt("nf_stall_cnt_3", {14'd0, b_stall}, 16'd3);
    drive(1, 2, 1, 3, 1, 12, 1, 0, 0); step("nf_add_x12", 1, ev(1, 1, 0, 0, F_R, F_R, RUN));
    drive(1, 12, 1, 0, 1, 13, 1, 0, 0); step("nf_stall_sat", 1, ev(0, 0, 0, 1, F_R, F_R, RUN));
    check_cnt("stall_cnt_saturated", {14'd0, b_stall}, 16'd3);
    // reset asserted while stalled in STALL
    drive(1, 12, 1, 0, 1, 13, 1, 0, 0);
    exp_q.push_back(ev(0, 0, 0, 1, F_R, F_R, STL));
    @(negedge clock);
    check_vec("stall_before_reset", 1);
    #1 reset_b = 1'b1;
    #1;
    exp_q.push_back(ev(1, 1, 0, 0, F_R, F_R, RUN));
    check_vec("reset_mid_stall", 1);
    check_cnt("reset_mid_stall_cnt", {14'd0, b_stall}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
